// File: rtl/decode_write_back_pipe.sv
// decode_write_back_pipe: Y86-64 D/W pipeline registers, register file and forwarded decode
module decode_write_back_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic        W_stall,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  output logic [3:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [63:0] d_valC,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode
);
  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] RSP = 4'h4;
  localparam logic [3:0] NONE = 4'hF;
  logic [3:0] dStat, dIcode, dIfun, dRA, dRB;
  logic [63:0] dValC, dValP;
  logic [3:0] wDstE, wDstM;
  logic [63:0] wValE, wValM;
  logic [63:0] rf [0:14];
  logic [63:0] rfA, rfB;
  // D register: stall holds, bubble injects a nop, otherwise load fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {dStat, dIcode, dIfun, dRA, dRB} <= {AOK, NOP, 4'h0, NONE, NONE};
      {dValC, dValP} <= '0;
    end else if (!D_stall) begin
      {dStat, dIcode, dIfun, dRA, dRB} <= D_bubble ? {AOK, NOP, 4'h0, NONE, NONE} : {f_stat, f_icode, f_ifun, f_rA, f_rB};
      {dValC, dValP} <= D_bubble ? 128'd0 : {f_valC, f_valP};
    end
  end
  // W register: loads memory-stage results unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {W_stat, W_icode, wDstE, wDstM} <= {AOK, NOP, NONE, NONE};
      {wValE, wValM} <= '0;
    end else if (!W_stall) begin
      {W_stat, W_icode, wDstE, wDstM} <= {m_stat, m_icode, m_dstE, m_dstM};
      {wValE, wValM} <= {m_valE, m_valM};
    end
  end
  // Register file write-back from pre-edge W; the later valM write wins on a shared destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (wDstE != NONE) rf[wDstE] <= wValE;
      if (wDstM != NONE) rf[wDstM] <= wValM;
    end
  end
  assign d_stat = dStat;
  assign d_icode = dIcode;
  assign d_ifun = dIfun;
  assign d_valC = dValC;
  assign d_srcA = (dIcode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? dRA : (dIcode inside {4'h9, 4'hB}) ? RSP : NONE;
  assign d_srcB = (dIcode inside {4'h4, 4'h5, 4'h6}) ? dRB : (dIcode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : NONE;
  assign d_dstE = (dIcode inside {4'h2, 4'h3, 4'h6}) ? dRB : (dIcode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : NONE;
  assign d_dstM = (dIcode inside {4'h5, 4'hB}) ? dRA : NONE;
  assign rfA = (d_srcA == NONE) ? 64'd0 : rf[d_srcA];
  assign rfB = (d_srcB == NONE) ? 64'd0 : rf[d_srcB];
  // Operand A: valP for jump/call, then youngest-first forwarding, then register file
  always_comb begin
    d_valA = (dIcode inside {4'h7, 4'h8}) ? dValP :
             (d_srcA == NONE) ? 64'd0 :
             (d_srcA == e_dstE) ? e_valE :
             (d_srcA == M_dstM) ? m_valM :
             (d_srcA == M_dstE) ? M_valE :
             (d_srcA == wDstM) ? wValM :
             (d_srcA == wDstE) ? wValE : rfA;
  end
  // Operand B: same forwarding chain without the valP term
  always_comb begin
    d_valB = (d_srcB == NONE) ? 64'd0 :
             (d_srcB == e_dstE) ? e_valE :
             (d_srcB == M_dstM) ? m_valM :
             (d_srcB == M_dstE) ? M_valE :
             (d_srcB == wDstM) ? wValM :
             (d_srcB == wDstE) ? wValE : rfB;
  end
endmodule

// File: tb/tb_decode_write_back_pipe.sv
// tb_decode_write_back_pipe: scoreboard bench with a behavioural Y86-64 decode/write-back model
module tb_decode_write_back_pipe;
  typedef struct packed {
    logic [3:0] stat, icode, ifun;
    logic [63:0] valC, valA, valB;
    logic [3:0] srcA, srcB, dstE, dstM, wStat, wIcode;
  } obs_t;
  logic clk = 0, rst_n = 0;
  logic [3:0] f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic D_stall, D_bubble, W_stall;
  logic [3:0] m_stat, m_icode, m_dstE, m_dstM, e_dstE, M_dstE, M_dstM;
  logic [63:0] m_valE, m_valM, e_valE, M_valE;
  logic [3:0] d_stat, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM, W_stat, W_icode;
  logic [63:0] d_valC, d_valA, d_valB;
  // model state
  logic [3:0] mdStat, mdIcode, mdIfun, mdRA, mdRB;
  logic [63:0] mdValC, mdValP;
  logic [3:0] mwStat, mwIcode, mwDstE, mwDstM;
  logic [63:0] mwValE, mwValM;
  logic [63:0] mrf [15];
  obs_t expQ[$];
  event chk;
  int checks = 0, errors = 0, step = 0;

  decode_write_back_pipe dut (
    .clk(clk), .rst_n(rst_n), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble), .m_stat(m_stat), .m_icode(m_icode),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .m_valE(m_valE), .m_valM(m_valM), .W_stall(W_stall), .e_dstE(e_dstE),
    .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .d_stat(d_stat), .d_icode(d_icode),
    .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .W_stat(W_stat), .W_icode(W_icode)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    {mdStat, mdIcode, mdIfun, mdRA, mdRB, mdValC, mdValP} = {4'h8, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
    {mwStat, mwIcode, mwDstE, mwDstM, mwValE, mwValM} = {4'h8, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0};
    for (int i = 0; i < 15; i++) mrf[i] = 64'd0;
  endtask

  function automatic logic [63:0] fwd(input logic [3:0] s);
    if (s == 4'hF) return 64'd0;
    if (s == e_dstE) return e_valE;
    if (s == M_dstM) return m_valM;
    if (s == M_dstE) return M_valE;
    if (s == mwDstM) return mwValM;
    if (s == mwDstE) return mwValE;
    return mrf[s];
  endfunction

  function automatic obs_t predict();
    obs_t o;
    int ic;
    ic = int'(mdIcode);
    o.stat = mdStat; o.icode = mdIcode; o.ifun = mdIfun; o.valC = mdValC;
    o.srcA = (ic == 2 || ic == 4 || ic == 6 || ic == 10) ? mdRA : (ic == 9 || ic == 11) ? 4'h4 : 4'hF;
    o.srcB = (ic == 4 || ic == 5 || ic == 6) ? mdRB : (ic >= 8 && ic <= 11) ? 4'h4 : 4'hF;
    o.dstE = (ic == 2 || ic == 3 || ic == 6) ? mdRB : (ic >= 8 && ic <= 11) ? 4'h4 : 4'hF;
    o.dstM = (ic == 5 || ic == 11) ? mdRA : 4'hF;
    o.valA = (ic == 7 || ic == 8) ? mdValP : fwd(o.srcA);
    o.valB = fwd(o.srcB);
    o.wStat = mwStat; o.wIcode = mwIcode;
    return o;
  endfunction

  task automatic modelEdge();
    if (!rst_n) return;
    if (mwDstE != 4'hF) mrf[mwDstE] = mwValE;
    if (mwDstM != 4'hF) mrf[mwDstM] = mwValM;
    if (!W_stall) {mwStat, mwIcode, mwDstE, mwDstM, mwValE, mwValM} = {m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM};
    if (!D_stall) begin
      if (D_bubble) {mdStat, mdIcode, mdIfun, mdRA, mdRB, mdValC, mdValP} = {4'h8, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
      else {mdStat, mdIcode, mdIfun, mdRA, mdRB, mdValC, mdValP} = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
    end
  endtask

  // issue: expectation for the current inputs, then one clock edge
  task automatic issue();
    expQ.push_back(predict());
    -> chk;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    step++;
  endtask

  task automatic setF(input logic [3:0] st, ic, fn, ra, rb, input logic [63:0] vc, vp);
    {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP} = {st, ic, fn, ra, rb, vc, vp};
  endtask

  function automatic logic [3:0] rid();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
  endfunction

  // monitor: compares the DUT against the oldest pending expectation
  always @(chk) begin
    obs_t e, got;
    #1;
    got = '{d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_srcA, d_srcB, d_dstE, d_dstM, W_stat, W_icode};
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL step%0d scoreboard empty", step);
    end else begin
      e = expQ.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL step%0d decode got=%h exp=%h", step, got, e);
      end
    end
  end

  initial begin
    setF(4'h8, 4'h1, 0, 4'hF, 4'hF, 0, 0);
    {D_stall, D_bubble, W_stall} = 3'b000;
    {m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM} = {4'h8, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0};
    {e_dstE, M_dstE, M_dstM, e_valE, M_valE} = {4'hF, 4'hF, 4'hF, 64'd0, 64'd0};
    modelReset();
    @(negedge clk);
    issue();
    rst_n = 1;
    setF(4'h8, 4'h3, 0, 4'h1, 4'h8, 64'd109, 64'd427);
    issue(); issue();
    setF(4'h8, 4'h6, 0, 4'h6, 4'h8, 64'd45, 64'd450);
    D_bubble = 1; issue();
    D_bubble = 0; issue(); issue();
    setF(4'h8, 4'h6, 0, 4'h3, 4'h8, 0, 0);
    {m_icode, m_valE, m_dstE} = {4'h1, 64'd78, 4'h3};
    issue();
    m_dstE = 4'hF; issue(); issue();
    D_stall = 1;
    {e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM} = {4'h3, 64'd5, 4'h3, 64'd9, 4'h3, 64'd7};
    issue();
    e_dstE = 4'hF; issue();
    M_dstM = 4'hF; issue();
    M_dstE = 4'hF; issue();
    setF(4'h2, 4'hB, 4'h5, 4'h7, 4'h2, 64'd1, 64'd2);
    issue();
    D_bubble = 1; issue();
    {D_stall, D_bubble} = 2'b00;
    setF(4'h8, 4'h8, 0, 4'hF, 4'hF, 0, 64'd450);
    issue(); issue();
    for (int n = 0; n < 400; n++) begin
      setF(($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 4)) : 4'h8, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 6)),
           rid(), rid(), {$urandom, $urandom}, {$urandom, $urandom});
      D_stall = ($urandom_range(0, 7) == 0);
      D_bubble = ($urandom_range(0, 7) == 0);
      W_stall = ($urandom_range(0, 7) == 0);
      {m_stat, m_icode, m_dstE, m_dstM} = {4'h8, 4'($urandom_range(0, 11)), rid(), rid()};
      {m_valE, m_valM} = {$urandom, $urandom, $urandom, $urandom};
      {e_dstE, M_dstE, M_dstM} = {rid(), rid(), rid()};
      {e_valE, M_valE} = {$urandom, $urandom, $urandom, $urandom};
      if (n == 200) begin
        #2 rst_n = 0;
        modelReset();
        issue(); issue();
        rst_n = 1;
      end
      issue();
    end
    #2 rst_n = 0;
    modelReset();
    {e_dstE, M_dstE, M_dstM} = {4'hF, 4'hF, 4'hF};
    issue();
    #3;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_write_back_pipe.md
# decode_write_back_pipe

Decode/write-back slice of the five-stage Y86-64 pipelined processor. Holds the D pipeline register (fetch→decode) and W pipeline register (memory→write-back), plus the 15×64-bit register file. Produces decoded operands with full forwarding from the E, M and W stages. Sits between fetch and execute; the write-back port is driven internally from the W register.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous active-low reset
- f_stat, f_icode, f_ifun, f_rA, f_rB  in  4 each  fetch outputs
- f_valC, f_valP  in  64 each  fetch constant / next PC
- D_stall, D_bubble  in  1 each  D register control
- m_stat, m_icode, m_dstE, m_dstM  in  4 each  memory-stage outputs into W
- m_valE, m_valM  in  64 each  memory-stage values into W; m_valM is also the forwarding source for M_dstM
- W_stall  in  1  W register hold
- e_dstE  in  4; e_valE  in  64  execute forwarding source
- M_dstE, M_dstM  in  4; M_valE  in  64  M-register forwarding sources
- d_stat, d_icode, d_ifun  out  4 each  pass-through of D_stat/D_icode/D_ifun
- d_valC  out  64  pass-through of D_valC
- d_valA, d_valB  out  64 each  forwarded operands
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  register IDs; 4'hF = none
- W_stat, W_icode  out  4 each  W register contents, for stat/halt logic

## Operation
- Stat encoding: AOK = 4'b1000; other stat values are carried unchanged.
- Icodes: 0 halt, 1 nop, 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq. RSP = 4'h4, none = 4'hF.
- D register loads all f_* fields on the rising edge. Stall and bubble rules:
  - D_stall = 1: hold. Stall has priority over bubble.
  - D_bubble = 1 (no stall): load the bubble value, which is stat AOK, icode 1, ifun 0, rA = rB = F, valC = valP = 0.
- W register (stat, icode, valE, valM, dstE, dstM) loads the m_* inputs each edge; W_stall = 1 holds it. W has no bubble.
- srcA:
  - rA for icode {2,4,6,A}
  - RSP for {9,B}
  - F otherwise
- srcB:
  - rB for {4,5,6}
  - RSP for {8,9,A,B}
  - F otherwise
- dstE:
  - rB for {2,3,6}
  - RSP for {8,9,A,B}
  - F otherwise
  - The cmov condition is resolved in execute, not here.
- dstM: rA for {5,B}, F otherwise.
- d_valA priority, first match wins:
  1. D_valP if icode ∈ {7,8}
  2. srcA==e_dstE → e_valE
  3. srcA==M_dstM → m_valM
  4. srcA==M_dstE → M_valE
  5. srcA==W_dstM → W_valM
  6. srcA==W_dstE → W_valE
  7. otherwise rf[srcA]
- d_valB uses the same chain without the valP term.
- No forwarding match is possible when src = F. Reading register F returns 0.
- Register file: regs 0–14. Combinational read.
  - On each rising edge, write W_valE to rf[W_dstE] if W_dstE≠F, then W_valM to rf[W_dstM] if W_dstM≠F.
  - If W_dstE == W_dstM, the valM write wins.

## Timing
- Reset, asynchronous and immediate:
  - D holds the bubble value.
  - W holds stat AOK, icode 1, valE = valM = 0, dstE = dstM = F.
  - All rf entries are 0.
  - Hence d_icode = 1, d_srcA = d_srcB = d_dstE = d_dstM = F, d_valA = d_valB = 0, W_stat = 4'b1000, W_icode = 1.
- D and W: one-cycle latency, input to register.
- All d_* outputs are combinational from D, W, rf and the forwarding inputs. No extra latency.
- Register-file write occurs on the same edge that W loads new contents, using the pre-edge W values.
  - Before that edge the W→decode forwarding path supplies the value; after it, rf supplies it.
- Edges while rst_n = 0 are ignored.

## Test plan
- Reset, then f = {stat 1000, icode 3, ifun 0, rA 1, rB 8, valC 109, valP 427}, one edge → D_icode 3, d_srcA = d_srcB = F, d_dstE 8, d_dstM F, d_valC 109, d_valA = d_valB = 0.
- With f = {icode 6, rA 6, rB 8, valC 45, valP 450}: assert D_bubble, edge → d_icode 1, all IDs F. Then deassert, edge → d_srcA 6, d_srcB 8, d_dstE 8.
- Write-back: m = {icode 1, valE 78, dstE 3, dstM F}, edge → W_dstE 3. Decode OPq rA = 3 → d_valA 78 (W forward). After the next edge with m_dstE = F → d_valA 78 from rf.
- Forwarding priority with srcA = 3, e_dstE 3/e_valE 5, M_dstE 3/M_valE 9, M_dstM 3/m_valM 7 → d_valA 5. Drop e_dstE → 7. Drop M_dstM → 9.
- Stall and control flow:
  - D_stall = 1 while f changes → D outputs unchanged.
  - D_stall + D_bubble → hold.
  - call (icode 8) with valP 450 → d_valA 450, d_srcB 4, d_dstE 4.
- Asynchronous reset mid-stream, with no clock edge → all outputs return to reset values immediately. rf[3] reads 0.
